// File: rtl/spi_vertex_rx.sv
// SPI mode-0 slave that assembles COMPONENTS x WORD_W-bit vertices from a serial
// stream and hands them to the pipeline through a first-word-fall-through FIFO.
module spi_vertex_rx #(
  parameter int WORD_W     = 16,
  parameter int COMPONENTS = 4,
  parameter int FIFO_DEPTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                         clock,
  input  logic                         io_aresetn,
  input  logic                         io_spi_sclk,
  input  logic                         io_spi_cs,
  input  logic                         io_spi_mosi,
  output logic                         io_spi_miso,
  output logic                         io_vtx_valid,
  input  logic                         io_vtx_ready,
  output logic [COMPONENTS*WORD_W-1:0] io_vtx_data,
  output logic [15:0]                  io_vtx_count,
  output logic                         io_frame_err,
  output logic                         io_overflow,
  input  logic                         io_clear
);

  localparam int VTX_W = COMPONENTS * WORD_W;
  localparam int BC_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int WC_W  = (COMPONENTS > 1) ? $clog2(COMPONENTS) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DRAIN
  } state_e;

  state_e            state_q;
  logic [2:0]        sclk_sync_q;   // {delay, stage2, stage1}
  logic [2:0]        cs_sync_q;
  logic [1:0]        mosi_sync_q;
  logic [WORD_W-1:0] shift_q;
  logic [BC_W-1:0]   bit_cnt_q;
  logic [WC_W-1:0]   word_cnt_q;
  logic [VTX_W-1:0]  vertex_q;
  logic [15:0]       vtx_count_q;
  logic              frame_err_q;
  logic              overflow_q;

  logic [VTX_W-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              full_q;

  logic              sclk_rise, cs_rise, cs_fall, mosi_s;
  logic [WORD_W-1:0] word_next;
  logic              drain, push, pop, drop;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign mosi_s    = mosi_sync_q[1];

  assign word_next = MSB_FIRST ? {shift_q[WORD_W-2:0], mosi_s}
                               : {mosi_s, shift_q[WORD_W-1:1]};

  assign drain = (state_q == DRAIN);
  assign pop   = io_vtx_valid & io_vtx_ready;
  // A full FIFO still accepts the vertex when the head leaves in the same cycle.
  assign push  = drain & (~full_q | pop);
  assign drop  = drain & ~push;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!io_aresetn) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      vertex_q    <= '0;
      vtx_count_q <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], io_spi_sclk};
      cs_sync_q   <= {cs_sync_q[1:0], io_spi_cs};
      mosi_sync_q <= {mosi_sync_q[0], io_spi_mosi};
      frame_err_q <= 1'b0;

      if (drop)          overflow_q <= 1'b1;
      else if (io_clear) overflow_q <= 1'b0;

      case (state_q)
        IDLE: begin
          bit_cnt_q  <= '0;
          word_cnt_q <= '0;
          if (cs_fall) begin
            state_q     <= SHIFT;
            vtx_count_q <= '0;
          end
        end

        SHIFT: begin
          if (cs_rise) begin
            state_q     <= IDLE;
            frame_err_q <= (bit_cnt_q != '0) || (word_cnt_q != '0);
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
          end else if (sclk_rise) begin
            shift_q <= word_next;
            if (bit_cnt_q == BC_W'(WORD_W-1)) begin
              bit_cnt_q <= '0;
              for (int c = 0; c < COMPONENTS; c++) begin
                if (word_cnt_q == WC_W'(c)) vertex_q[c*WORD_W +: WORD_W] <= word_next;
              end
              if (word_cnt_q == WC_W'(COMPONENTS-1)) state_q <= DRAIN;
              else                                   word_cnt_q <= word_cnt_q + WC_W'(1);
            end else begin
              bit_cnt_q <= bit_cnt_q + BC_W'(1);
            end
          end
        end

        DRAIN: begin
          if (vtx_count_q != 16'hFFFF) vtx_count_q <= vtx_count_q + 16'd1;
          word_cnt_q <= '0;
          if (cs_rise) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
          end else begin
            state_q <= SHIFT;
            // The first bit of the next vertex may arrive while draining.
            if (sclk_rise) begin
              shift_q   <= word_next;
              bit_cnt_q <= bit_cnt_q + BC_W'(1);
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!io_aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == (AW+1)'(FIFO_DEPTH));
    end
  end

  // NOTE: FIFO storage is not reset; the occupancy counter alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= vertex_q;
  end

  assign io_vtx_valid = (count_q != '0);
  assign io_vtx_data  = io_vtx_valid ? mem_q[rd_ptr_q] : '0;
  assign io_spi_miso  = full_q;
  assign io_vtx_count = vtx_count_q;
  assign io_frame_err = frame_err_q;
  assign io_overflow  = overflow_q;

endmodule
